// File: rtl/apb_axi_pkg.sv
// rtl/apb_axi_pkg.sv - state encoding and AXI response codes for apb_axi_bridge
package apb_axi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_RD_REQ,
    ST_RD_RESP,
    ST_DONE
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/apb_axi_bridge.sv
// rtl/apb_axi_bridge.sv - APB slave to AXI4-Lite master bridge, one transfer in flight
// Optional APB_AXI_PSTRB_EN: adds apb_pstrb, forwarded to axi_wstrb.
module apb_axi_bridge
  import apb_axi_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32
) (
  input  logic                        axi_aclk,
  input  logic                        axi_aresetn,
  input  logic [APB_ADDR_WIDTH-1:0]   apb_paddr,
  input  logic [2:0]                  apb_pprot,
  input  logic                        apb_psel,
  input  logic                        apb_penable,
  input  logic                        apb_pwrite,
  input  logic [APB_DATA_WIDTH-1:0]   apb_pwdata,
`ifdef APB_AXI_PSTRB_EN
  input  logic [APB_DATA_WIDTH/8-1:0] apb_pstrb,
`endif
  output logic [APB_DATA_WIDTH-1:0]   apb_prdata,
  output logic                        apb_pready,
  output logic                        apb_pslverr,
  output logic [AXI_ADDR_WIDTH-1:0]   axi_awaddr,
  output logic [2:0]                  axi_awprot,
  output logic                        axi_awvalid,
  input  logic                        axi_awready,
  output logic [AXI_DATA_WIDTH-1:0]   axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb,
  output logic                        axi_wvalid,
  input  logic                        axi_wready,
  input  logic [1:0]                  axi_bresp,
  input  logic                        axi_bvalid,
  output logic                        axi_bready,
  output logic [AXI_ADDR_WIDTH-1:0]   axi_araddr,
  output logic [2:0]                  axi_arprot,
  output logic                        axi_arvalid,
  input  logic                        axi_arready,
  input  logic [AXI_DATA_WIDTH-1:0]   axi_rdata,
  input  logic [1:0]                  axi_rresp,
  input  logic                        axi_rvalid,
  output logic                        axi_rready
);

  localparam int ADDR_COPY = (APB_ADDR_WIDTH < AXI_ADDR_WIDTH) ? APB_ADDR_WIDTH : AXI_ADDR_WIDTH;

  state_e                      state_q;
  logic [APB_DATA_WIDTH-1:0]   prdata_q;
  logic                        pready_q, pslverr_q;
  logic [AXI_ADDR_WIDTH-1:0]   awaddr_q, araddr_q;
  logic [2:0]                  awprot_q, arprot_q;
  logic                        awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic [AXI_DATA_WIDTH-1:0]   wdata_q;
  logic [AXI_DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic [AXI_ADDR_WIDTH-1:0]   addr_ext;

  // paddr is zero-extended or truncated onto the AXI address bus
  always_comb begin
    addr_ext = '0;
    addr_ext[ADDR_COPY-1:0] = apb_paddr[ADDR_COPY-1:0];
  end

`ifdef APB_AXI_PSTRB_EN
  assign wstrb_d = apb_pstrb;
`else
  assign wstrb_d = '1;
`endif

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q   <= ST_IDLE;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      awaddr_q  <= '0;
      awprot_q  <= '0;
      awvalid_q <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      araddr_q  <= '0;
      arprot_q  <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // only a setup phase starts a transfer; a bare access phase is ignored
          if (apb_psel && !apb_penable) begin
            if (apb_pwrite) begin
              awaddr_q  <= addr_ext;
              awprot_q  <= apb_pprot;
              wdata_q   <= apb_pwdata;
              wstrb_q   <= wstrb_d;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              prdata_q  <= '0;
              state_q   <= ST_WR_REQ;
            end else begin
              araddr_q  <= addr_ext;
              arprot_q  <= apb_pprot;
              arvalid_q <= 1'b1;
              state_q   <= ST_RD_REQ;
            end
          end
        end
        ST_WR_REQ: begin
          if (awvalid_q && axi_awready) awvalid_q <= 1'b0;
          if (wvalid_q && axi_wready) wvalid_q <= 1'b0;
          if ((!awvalid_q || axi_awready) && (!wvalid_q || axi_wready)) begin
            bready_q <= 1'b1;
            state_q  <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (axi_bvalid) begin
            bready_q  <= 1'b0;
            pslverr_q <= resp_is_err(axi_bresp);
            pready_q  <= 1'b1;
            state_q   <= ST_DONE;
          end
        end
        ST_RD_REQ: begin
          if (axi_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_RD_RESP;
          end
        end
        ST_RD_RESP: begin
          if (axi_rvalid) begin
            rready_q  <= 1'b0;
            prdata_q  <= axi_rdata;
            pslverr_q <= resp_is_err(axi_rresp);
            pready_q  <= 1'b1;
            state_q   <= ST_DONE;
          end
        end
        ST_DONE: begin
          pready_q  <= 1'b0;
          pslverr_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign apb_prdata  = prdata_q;
  assign apb_pready  = pready_q;
  assign apb_pslverr = pslverr_q;
  assign axi_awaddr  = awaddr_q;
  assign axi_awprot  = awprot_q;
  assign axi_awvalid = awvalid_q;
  assign axi_wdata   = wdata_q;
  assign axi_wstrb   = wstrb_q;
  assign axi_wvalid  = wvalid_q;
  assign axi_bready  = bready_q;
  assign axi_araddr  = araddr_q;
  assign axi_arprot  = arprot_q;
  assign axi_arvalid = arvalid_q;
  assign axi_rready  = rready_q;

endmodule

// File: tb/tb_apb_axi_bridge.sv
// tb/tb_apb_axi_bridge.sv - scoreboard testbench for apb_axi_bridge
module tb_apb_axi_bridge;
  import apb_axi_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int OUTW = 2 * DW + 2 * AW + SW + 13;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] apb_paddr;
  logic [2:0]    apb_pprot;
  logic          apb_psel, apb_penable, apb_pwrite;
  logic [DW-1:0] apb_pwdata;
  logic [SW-1:0] tb_pstrb;
  logic [DW-1:0] apb_prdata;
  logic          apb_pready, apb_pslverr;
  logic [AW-1:0] axi_awaddr, axi_araddr;
  logic [2:0]    axi_awprot, axi_arprot;
  logic          axi_awvalid, axi_awready, axi_wvalid, axi_wready;
  logic [DW-1:0] axi_wdata, axi_rdata;
  logic [SW-1:0] axi_wstrb;
  logic [1:0]    axi_bresp, axi_rresp;
  logic          axi_bvalid, axi_bready, axi_arvalid, axi_arready, axi_rvalid, axi_rready;
  logic [OUTW-1:0] all_outs;

  assign all_outs = {apb_prdata, apb_pready, apb_pslverr, axi_awaddr, axi_awprot, axi_awvalid,
                     axi_wdata, axi_wstrb, axi_wvalid, axi_bready, axi_araddr, axi_arprot,
                     axi_arvalid, axi_rready};

  apb_axi_bridge dut (
    .axi_aclk    (clk),
    .axi_aresetn (rst_n),
    .apb_paddr   (apb_paddr),
    .apb_pprot   (apb_pprot),
    .apb_psel    (apb_psel),
    .apb_penable (apb_penable),
    .apb_pwrite  (apb_pwrite),
    .apb_pwdata  (apb_pwdata),
`ifdef APB_AXI_PSTRB_EN
    .apb_pstrb   (tb_pstrb),
`endif
    .apb_prdata  (apb_prdata),
    .apb_pready  (apb_pready),
    .apb_pslverr (apb_pslverr),
    .axi_awaddr  (axi_awaddr),
    .axi_awprot  (axi_awprot),
    .axi_awvalid (axi_awvalid),
    .axi_awready (axi_awready),
    .axi_wdata   (axi_wdata),
    .axi_wstrb   (axi_wstrb),
    .axi_wvalid  (axi_wvalid),
    .axi_wready  (axi_wready),
    .axi_bresp   (axi_bresp),
    .axi_bvalid  (axi_bvalid),
    .axi_bready  (axi_bready),
    .axi_araddr  (axi_araddr),
    .axi_arprot  (axi_arprot),
    .axi_arvalid (axi_arvalid),
    .axi_arready (axi_arready),
    .axi_rdata   (axi_rdata),
    .axi_rresp   (axi_rresp),
    .axi_rvalid  (axi_rvalid),
    .axi_rready  (axi_rready)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  typedef struct { logic [AW-1:0] addr; logic [2:0] prot; } areq_t;
  typedef struct { logic [DW-1:0] data; logic [SW-1:0] strb; } wreq_t;
  typedef struct { logic rd; logic err; logic [DW-1:0] data; } apb_t;

  areq_t exp_aw[$];
  areq_t exp_ar[$];
  wreq_t exp_w[$];
  apb_t  exp_apb[$];

  // slave behaviour knobs
  int aw_lat = 0, w_lat = 0, ar_lat = 0, b_lat = 0, r_lat = 0;
  logic [1:0]    b_resp_cfg = RESP_OKAY;
  logic [1:0]    r_resp_cfg = RESP_OKAY;
  logic [DW-1:0] r_data_cfg = '0;
  int awv_cyc = 0, wv_cyc = 0, arv_cyc = 0;

  int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
  bit aw_seen, w_seen, b_pend, r_pend, hs_aw, hs_w, hs_ar, hs_b, hs_r;
  areq_t s_a;
  wreq_t s_w;

  initial begin
    axi_awready = 0; axi_wready = 0; axi_arready = 0;
    axi_bvalid = 0; axi_bresp = 0; axi_rvalid = 0; axi_rresp = 0; axi_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        axi_awready = 0; axi_wready = 0; axi_arready = 0; axi_bvalid = 0; axi_rvalid = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
        aw_seen = 0; w_seen = 0; b_pend = 0; r_pend = 0;
        hs_aw = 0; hs_w = 0; hs_ar = 0; hs_b = 0; hs_r = 0;
        continue;
      end
      if (hs_b) axi_bvalid = 0;
      if (hs_r) axi_rvalid = 0;
      if (hs_aw) aw_seen = 1;
      if (hs_w) w_seen = 1;
      if (hs_ar) begin r_pend = 1; r_cnt = 0; end
      if (aw_seen && w_seen) begin aw_seen = 0; w_seen = 0; b_pend = 1; b_cnt = 0; end
      if (b_pend) begin
        if (b_cnt >= b_lat) begin axi_bvalid = 1; axi_bresp = b_resp_cfg; b_pend = 0; end
        else b_cnt++;
      end
      if (r_pend) begin
        if (r_cnt >= r_lat) begin
          axi_rvalid = 1; axi_rresp = r_resp_cfg; axi_rdata = r_data_cfg; r_pend = 0;
        end else r_cnt++;
      end
      if (axi_awvalid) awv_cyc++;
      if (axi_wvalid) wv_cyc++;
      if (axi_arvalid) arv_cyc++;
      axi_awready = axi_awvalid && (aw_cnt >= aw_lat);
      axi_wready  = axi_wvalid && (w_cnt >= w_lat);
      axi_arready = axi_arvalid && (ar_cnt >= ar_lat);
      aw_cnt = axi_awvalid ? aw_cnt + 1 : 0;
      w_cnt  = axi_wvalid ? w_cnt + 1 : 0;
      ar_cnt = axi_arvalid ? ar_cnt + 1 : 0;
      hs_aw = axi_awvalid && axi_awready;
      hs_w  = axi_wvalid && axi_wready;
      hs_ar = axi_arvalid && axi_arready;
      hs_b  = axi_bvalid && axi_bready;
      hs_r  = axi_rvalid && axi_rready;
      if (hs_aw) begin
        if (exp_aw.size() == 0) begin checks++; failures++; $display("FAIL aw_unexpected addr=0x%0h", axi_awaddr); end
        else begin s_a = exp_aw.pop_front(); chk("aw_addr", axi_awaddr, s_a.addr); chk("aw_prot", axi_awprot, s_a.prot); end
      end
      if (hs_w) begin
        if (exp_w.size() == 0) begin checks++; failures++; $display("FAIL w_unexpected data=0x%0h", axi_wdata); end
        else begin s_w = exp_w.pop_front(); chk("w_data", axi_wdata, s_w.data); chk("w_strb", axi_wstrb, s_w.strb); end
      end
      if (hs_ar) begin
        if (exp_ar.size() == 0) begin checks++; failures++; $display("FAIL ar_unexpected addr=0x%0h", axi_araddr); end
        else begin s_a = exp_ar.pop_front(); chk("ar_addr", axi_araddr, s_a.addr); chk("ar_prot", axi_arprot, s_a.prot); end
      end
    end
  end

  logic prev_pready = 0;
  apb_t m_e;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && apb_pready) begin
        chk("pready_single_cycle", prev_pready, 0);
        if (exp_apb.size() == 0) begin checks++; failures++; $display("FAIL apb_unexpected_pready actual=1 required=0"); end
        else begin
          m_e = exp_apb.pop_front();
          chk("pslverr", apb_pslverr, m_e.err);
          if (m_e.rd) chk("prdata", apb_prdata, m_e.data);
        end
      end
      prev_pready = apb_pready;
    end
  end

  task automatic apb_xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                          input logic [SW-1:0] strb, input logic [2:0] prot,
                          output int lat, output int bready_at);
    @(negedge clk);
    apb_psel = 1; apb_penable = 0; apb_pwrite = wr; apb_paddr = addr;
    apb_pwdata = data; apb_pprot = prot; tb_pstrb = strb;
    awv_cyc = 0; wv_cyc = 0; arv_cyc = 0;
    lat = 0; bready_at = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      lat++;
      apb_penable = 1;
      if (bready_at == 0 && axi_bready) bready_at = lat;
      if (apb_pready) break;
    end
    if (!apb_pready) begin
      checks++; failures++;
      $display("FAIL apb_timeout addr=0x%0h actual=no_pready required=pready", addr);
    end
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic [SW-1:0] strb,
                          input logic [2:0] prot, input logic err, output int lat, output int bready_at);
    areq_t a; wreq_t w; apb_t p;
    a.addr = addr; a.prot = prot; exp_aw.push_back(a);
    w.data = data;
`ifdef APB_AXI_PSTRB_EN
    w.strb = strb;
`else
    w.strb = '1;
`endif
    exp_w.push_back(w);
    p.rd = 0; p.err = err; p.data = '0; exp_apb.push_back(p);
    apb_xfer(1'b1, addr, data, strb, prot, lat, bready_at);
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input logic [2:0] prot, input logic [DW-1:0] rdata,
                         input logic err, output int lat);
    areq_t a; apb_t p; int br;
    a.addr = addr; a.prot = prot; exp_ar.push_back(a);
    p.rd = 1; p.err = err; p.data = rdata; exp_apb.push_back(p);
    apb_xfer(1'b0, addr, '0, '0, prot, lat, br);
  endtask

  int lat, br;
  bit stray;

  initial begin
    apb_psel = 0; apb_penable = 0; apb_pwrite = 0; apb_paddr = '0;
    apb_pwdata = '0; apb_pprot = '0; tb_pstrb = '0;
    rst_n = 0;
    repeat (3) @(negedge clk);
    chk("reset_outputs_zero", $countones(all_outs), 0);
    rst_n = 1;

    // access phase with no setup: nothing may happen
    @(negedge clk);
    apb_psel = 1; apb_penable = 1; apb_pwrite = 1; apb_paddr = 32'h8;
    stray = 0;
    repeat (4) begin
      @(negedge clk);
      if (axi_awvalid || axi_wvalid || axi_arvalid || apb_pready) stray = 1;
    end
    chk("stray_access_ignored", stray, 0);
    apb_psel = 0; apb_penable = 0;

    b_resp_cfg = RESP_OKAY;
    do_write(32'h10, 32'hDEADBEEF, 4'hF, 3'b000, 1'b0, lat, br);
    chk("wr1_latency", lat, 3);

    ar_lat = 3; r_resp_cfg = RESP_SLVERR; r_data_cfg = 32'h12345678;
    do_read(32'h20, 3'b010, 32'h12345678, 1'b1, lat);
    chk("rd1_arvalid_cycles", arv_cyc, 4);
    chk("rd1_latency", lat, 6);
    ar_lat = 0;

    w_lat = 3;
    do_write(32'h14, 32'hA5A50F0F, 4'hF, 3'b001, 1'b0, lat, br);
    chk("wr2_awvalid_cycles", awv_cyc, 1);
    chk("wr2_wvalid_cycles", wv_cyc, 4);
    chk("wr2_bready_cycle", br, 5);
    chk("wr2_latency", lat, 6);
    w_lat = 0;

    r_resp_cfg = RESP_DECERR; r_data_cfg = 32'hCAFEF00D;
    do_read(32'h30, 3'b000, 32'hCAFEF00D, 1'b1, lat);
    chk("rd2_latency", lat, 3);
    b_resp_cfg = RESP_OKAY;
    do_write(32'h40, 32'h0BADF00D, 4'hF, 3'b000, 1'b0, lat, br);
    chk("b2b_wr_latency", lat, 3);

    // reset while waiting for the write response
    b_lat = 20;
    begin
      areq_t a; wreq_t w;
      a.addr = 32'h44; a.prot = 3'b000; exp_aw.push_back(a);
      w.data = 32'h11223344; w.strb = '1; exp_w.push_back(w);
    end
    @(negedge clk);
    apb_psel = 1; apb_penable = 0; apb_pwrite = 1; apb_paddr = 32'h44;
    apb_pwdata = 32'h11223344; apb_pprot = 3'b000; tb_pstrb = '1;
    @(negedge clk);
    apb_penable = 1;
    for (int i = 0; i < 20 && !axi_bready; i++) @(negedge clk);
    chk("rst_reached_wr_resp", axi_bready, 1);
    #2;
    rst_n = 0; apb_psel = 0; apb_penable = 0;
    @(negedge clk);
    chk("rst_mid_outputs_zero", $countones(all_outs), 0);
    @(negedge clk);
    rst_n = 1; b_lat = 0;
    r_resp_cfg = RESP_OKAY; r_data_cfg = 32'h55AA55AA;
    do_read(32'h50, 3'b000, 32'h55AA55AA, 1'b0, lat);
    chk("rd_after_rst_latency", lat, 3);

`ifdef APB_AXI_PSTRB_EN
    do_write(32'h60, 32'hFFFF0000, 4'h5, 3'b000, 1'b0, lat, br);
    chk("pstrb_wr_latency", lat, 3);
`endif

    @(negedge clk);
    apb_psel = 0; apb_penable = 0;
    repeat (5) @(negedge clk);
    chk("aw_queue_drained", exp_aw.size(), 0);
    chk("w_queue_drained", exp_w.size(), 0);
    chk("ar_queue_drained", exp_ar.size(), 0);
    chk("apb_queue_drained", exp_apb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/apb_axi_bridge.md
Name: apb_axi_bridge

Overview:
- APB slave to AXI4-Lite master bridge; the reverse direction of the AXI-to-APB bridge already in the design.
- Lets an APB-attached master (e.g. a debug or config controller) reach AXI-Lite slaves.
- Accepts one APB transfer at a time and issues a single AXI-Lite read or write for it.
- Holds apb_pready low until the AXI response returns, then completes the APB access phase.

Parameters:
- AXI_ADDR_WIDTH, 32, AXI address width.
- AXI_DATA_WIDTH, 32, AXI data width; must equal APB_DATA_WIDTH (32 or 64).
- APB_ADDR_WIDTH, 32, APB address width; paddr is zero-extended or truncated to AXI_ADDR_WIDTH.
- APB_DATA_WIDTH, 32, APB data width.

Ports:
- axi_aclk  in  1  single clock for both interfaces.
- axi_aresetn  in  1  asynchronous active-low reset.
- apb_paddr  in  APB_ADDR_WIDTH  APB address.
- apb_pprot  in  3  protection; forwarded to axi_awprot/axi_arprot.
- apb_psel  in  1  select.
- apb_penable  in  1  access phase.
- apb_pwrite  in  1  1=write, 0=read.
- apb_pwdata  in  APB_DATA_WIDTH  write data.
- apb_prdata  out  APB_DATA_WIDTH  read data.
- apb_pready  out  1  transfer complete.
- apb_pslverr  out  1  error; valid with pready.
- axi_awaddr/axi_awprot/axi_awvalid out, axi_awready in  AXI_ADDR_WIDTH/3/1/1  AW channel.
- axi_wdata/axi_wstrb/axi_wvalid out, axi_wready in  AXI_DATA_WIDTH/AXI_DATA_WIDTH/8/1/1  W channel.
- axi_bresp in 2, axi_bvalid in 1, axi_bready out 1  B channel.
- axi_araddr/axi_arprot/axi_arvalid out, axi_arready in  AXI_ADDR_WIDTH/3/1/1  AR channel.
- axi_rdata in AXI_DATA_WIDTH, axi_rresp in 2, axi_rvalid in 1, axi_rready out 1  R channel.

Behaviour:
- All outputs are registered. Reset value of every output is 0, including all valid/ready strobes, pready, pslverr, prdata, addresses, data and strobes.
- States:
  - IDLE: on a setup phase (psel=1, penable=0), capture paddr, pwdata, pprot, pwrite. Go to WR_REQ (pwrite=1) or RD_REQ (pwrite=0).
  - WR_REQ: awvalid and wvalid are driven high together on entry. Each drops independently on its own handshake (valid & ready). When both have handshaken (possibly in different cycles), go to WR_RESP.
  - WR_RESP: bready=1. On bvalid, capture bresp and go to DONE.
  - RD_REQ: arvalid=1 until arready, then go to RD_RESP.
  - RD_RESP: rready=1. On rvalid, capture rdata into apb_prdata and rresp, then go to DONE.
  - DONE: pready=1 for exactly one cycle, pslverr=(resp[1]==1), i.e. SLVERR or DECERR. Then return to IDLE.
- Valid signals never drop before their handshake. Address, data and prot are stable while valid is high.
- bready and rready are low outside WR_RESP and RD_RESP.
- Minimum latency: setup edge T0; AW/W/AR valid at T1; with ready=1 at T1 and response at T2, pready is high at T3.
- pready is low in every state except DONE. pslverr and prdata are 0 outside DONE for writes; for reads, prdata holds its last captured value.
- An access phase (psel=1, penable=1) seen in IDLE without a preceding setup is ignored; no AXI traffic is generated.
- psel dropped mid-transaction: the AXI transaction still completes and DONE still pulses. No new transfer is accepted until IDLE.
- Back-to-back APB transfers: the next setup is accepted only in IDLE, i.e. the cycle after DONE.
- AW and W handshaking in the same cycle and in either order are both legal.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0; the in-flight transaction is abandoned.
- wstrb is all ones (feature disabled).

Optional Feature:
- Macro: APB_AXI_PSTRB_EN.
- Defined: adds port apb_pstrb (in, APB_DATA_WIDTH/8, APB4 byte strobes). It is captured at setup and driven on axi_wstrb. A write with pstrb=0 still issues AXI traffic.
- Undefined: no apb_pstrb port; axi_wstrb is tied to all ones.

Decomposition:
- Package apb_axi_pkg holds:
  - the state encoding (IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE);
  - AXI response constants (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11).
- Single module; no sub-module is natural at this size.

Test Plan:
- Write paddr=0x10, pwdata=0xDEADBEEF, ready=1, bresp=OKAY -> awaddr=0x10, wdata=0xDEADBEEF, wstrb=0xF; pready=1 at T3; pslverr=0.
- Read paddr=0x20, arready delayed 3 cycles, rdata=0x12345678, rresp=SLVERR -> arvalid held 4 cycles; prdata=0x12345678; pslverr=1.
- Write with awready at T1 and wready at T4 -> awvalid drops after T1, wvalid held to T4, bready rises at T5.
- Read with rresp=DECERR -> pslverr=1. Then a back-to-back write with bresp=OKAY -> pslverr=0 and a second AXI write is issued.
- Reset asserted in WR_RESP -> all outputs 0 next cycle; a subsequent read completes normally.
- With APB_AXI_PSTRB_EN defined, pstrb=0x5 -> wstrb=0x5.
